pc_sequencer: RTL and testbench

Fetch-stage controller that owns the program counter register and sequences instruction fetch for the pipelined processor. Arbitrates next-PC sources by fixed priority: trap, EX branch, ID jump, hazard stall, sequential PC+4. Drives the instruction-memory request/ready handshake and produces the IF-stage valid and pipeline flush strobes consumed by the IF/ID and ID/EX registers.

---
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, arbitrates next-PC
// sources and drives the instruction-memory request and flush strobes.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        trap,
  input  logic        halt,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid,
  output logic        flush_if,
  output logic        flush_id,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req  = (state == FETCH);
  assign halted    = (state == HALTED);

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    if_valid = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        if (trap) begin
          pc_nx    = TRAP_VECTOR & ALIGN;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (br_taken) begin
          pc_nx    = br_target & ALIGN;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (jump) begin
          pc_nx    = jump_target & ALIGN;
          flush_if = 1'b1;
        end else if (halt) begin
          state_nx = HALTED;
          flush_if = 1'b1;
        end else if (stall) begin
          pc_nx = pc;
        end else if (imem_ready) begin
          pc_nx    = pc_plus4;
          if_valid = 1'b1;
        end
      end
      HALTED: begin
        // only a trap (or reset) wakes the sequencer
        if (trap) begin
          pc_nx    = TRAP_VECTOR & ALIGN;
          state_nx = FETCH;
          flush_if = 1'b1;
          flush_id = 1'b1;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
      pc    <= RESET_VECTOR & ALIGN;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected per-cycle outputs are queued
// as stimulus is applied and popped for comparison mid-cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken, jump, trap, halt, imem_ready;
  logic [31:0] br_target, jump_target;
  logic        imem_req, if_valid, flush_if, flush_id, halted;
  logic [31:0] imem_addr, pc, pc_plus4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        req;
    logic        v;
    logic        fi;
    logic        fd;
    logic        h;
  } exp_t;

  exp_t sb[$];

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jump(jump), .jump_target(jump_target),
    .trap(trap), .halt(halt), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .pc_plus4(pc_plus4), .if_valid(if_valid),
    .flush_if(flush_if), .flush_id(flush_id), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check_front();
    exp_t e;
    logic [100:0] obs, ex;
    e = sb.pop_front();
    obs = {pc, imem_addr, pc_plus4,
           imem_req, if_valid, flush_if, flush_id, halted};
    ex  = {e.pc, e.pc, e.pc + 32'd4,
           e.req, e.v, e.fi, e.fd, e.h};
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, ex);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] p,
                            input logic rq, input logic v,
                            input logic fi, input logic fd,
                            input logic h);
    exp_t e;
    e.tag = tag; e.pc = p; e.req = rq;
    e.v = v; e.fi = fi; e.fd = fd; e.h = h;
    sb.push_back(e);
    #2;
    check_front();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    stall = 0; br_taken = 0; jump = 0; trap = 0; halt = 0;
    br_target = 0; jump_target = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    reset = 1; imem_ready = 1; trap = 1;
    expect_now("reset", 32'h0, 0, 0, 0, 0, 0);
    tick();
    trap = 0; reset = 0;
    expect_now("boot", 32'h0, 0, 0, 0, 0, 0);
    tick();
    expect_now("seq0", 32'h0, 1, 1, 0, 0, 0); tick();
    expect_now("seq4", 32'h4, 1, 1, 0, 0, 0); tick();
    expect_now("seq8", 32'h8, 1, 1, 0, 0, 0); tick();
    expect_now("seqc", 32'hC, 1, 1, 0, 0, 0); tick();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      expect_now("wait", 32'h10, 1, 0, 0, 0, 0); tick();
    end
    imem_ready = 1;
    expect_now("ready10", 32'h10, 1, 1, 0, 0, 0); tick();
    br_taken = 1; br_target = 32'h203;
    jump = 1; jump_target = 32'h400;
    expect_now("br_jump", 32'h14, 1, 0, 1, 1, 0); tick();
    clr(); imem_ready = 0;
    expect_now("br_tgt", 32'h200, 1, 0, 0, 0, 0);
    jump = 1; jump_target = 32'h40;
    #1;
    expect_now("jmp40", 32'h200, 1, 0, 1, 0, 0); tick();
    clr(); imem_ready = 1; stall = 1;
    expect_now("stall1", 32'h40, 1, 0, 0, 0, 0); tick();
    expect_now("stall2", 32'h40, 1, 0, 0, 0, 0); tick();
    jump = 1; jump_target = 32'h80;
    expect_now("stall_jmp", 32'h40, 1, 0, 1, 0, 0); tick();
    clr();
    expect_now("at80", 32'h80, 1, 1, 0, 0, 0); tick();
    jump = 1; jump_target = 32'h24;
    expect_now("jmp24", 32'h84, 1, 0, 1, 0, 0); tick();
    clr(); halt = 1;
    expect_now("halt", 32'h24, 1, 0, 1, 0, 0); tick();
    clr(); br_taken = 1; br_target = 32'h300;
    jump = 1; jump_target = 32'h500; stall = 1; halt = 1;
    expect_now("halted", 32'h24, 0, 0, 0, 0, 1); tick();
    expect_now("halted2", 32'h24, 0, 0, 0, 0, 1); tick();
    clr(); trap = 1;
    expect_now("wake_trap", 32'h24, 0, 0, 1, 1, 1); tick();
    clr();
    expect_now("trap80", 32'h80, 1, 1, 0, 0, 0); tick();
    trap = 1; br_taken = 1; br_target = 32'h500;
    jump = 1; jump_target = 32'h600;
    expect_now("trap_pri", 32'h84, 1, 0, 1, 1, 0); tick();
    clr();
    jump = 1; jump_target = 32'hFFFF_FFFF;
    expect_now("jmp_top", 32'h80, 1, 0, 1, 0, 0); tick();
    clr();
    expect_now("top", 32'hFFFF_FFFC, 1, 1, 0, 0, 0); tick();
    expect_now("wrap", 32'h0, 1, 1, 0, 0, 0); tick();
    imem_ready = 0;
    expect_now("midwait", 32'h4, 1, 0, 0, 0, 0);
    reset = 1;
    expect_now("async_rst", 32'h0, 0, 0, 0, 0, 0);
    tick();
    reset = 0; trap = 1; imem_ready = 1;
    expect_now("boot2", 32'h0, 0, 0, 0, 0, 0); tick();
    trap = 0;
    expect_now("fetch2", 32'h0, 1, 1, 0, 0, 0); tick();
    expect_now("fetch2b", 32'h4, 1, 1, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
